apb_sram_slave: RTL and testbench
=================================

APB_SRAM_SLAVE -- requirements
Module: apb_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, meaning number of 32-bit words stored; power of two, at least 4.
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning wait cycles inserted in every access phase; range 0..15.
REQ-003 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port psel  input  1  APB select.
REQ-006 SHALL have port penable  input  1  APB access phase.
REQ-007 SHALL have port pwrite  input  1  1 = write, 0 = read.
REQ-008 SHALL have port paddr  input  32  byte address.
REQ-009 SHALL have port pwdata  input  32  write data.
REQ-010 SHALL have port pstrb  input  4  byte write strobes; bit i enables pwdata[8i+7:8i].
REQ-011 SHALL have port prdata  output  32  read data.
REQ-012 SHALL have port pready  output  1  transfer completes this cycle.
REQ-013 SHALL have port pslverr  output  1  error response; valid only while pready=1.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, WAIT and DONE.
REQ-015 IDLE->WAIT SHALL occur on psel=1 & penable=0 (setup) when WAIT_STATES>0; IDLE->DONE SHALL occur on setup when WAIT_STATES=0.
REQ-016 Setup edge SHALL latch paddr, pwrite, pwdata and pstrb, and SHALL load a 4-bit wait counter with WAIT_STATES-1.
REQ-017 WAIT SHALL decrement the counter each cycle with psel=1 & penable=1, and SHALL go to DONE on the cycle after the counter reads 0.
REQ-018 pready SHALL be 1 only in DONE, so it rises in access cycle WAIT_STATES+1 and lasts exactly one cycle.
REQ-019 DONE SHALL return to IDLE unconditionally; a setup in the next cycle SHALL start a new transfer (back-to-back supported).
REQ-020 psel=0 while in WAIT or DONE SHALL abort: go to IDLE, no memory write, pready=0.
REQ-021 penable=1 seen in IDLE SHALL be ignored (no transfer, pready=0).
REQ-022 Word index SHALL be latched paddr[log2(DEPTH_WORDS)+1:2].
REQ-023 Error SHALL be flagged when paddr[1:0]!=0 or paddr >= 4*DEPTH_WORDS; pslverr SHALL be 1 in DONE for an errored transfer, else 0.
REQ-024 Read SHALL use synchronous RAM, addressed at the setup edge, with prdata registered and held stable from the first access cycle through DONE.
REQ-025 prdata SHALL be 32'h0 for errored reads and for writes.
REQ-026 Write SHALL commit on the clock edge ending DONE, updating only the bytes whose pstrb bit is 1; pstrb=0 SHALL be a legal no-op write with pslverr=0.
REQ-027 Errored writes SHALL not modify memory.
REQ-028 A read issued in the setup cycle immediately after a write DONE to the same word SHALL return the newly written data.
REQ-029 Memory contents SHALL be uninitialised and SHALL NOT be cleared by rst.

Reset
REQ-030 rst=1 SHALL force state IDLE, counter 0, pready=0, pslverr=0 and prdata=32'h0 on the next edge.
REQ-031 rst asserted mid-transfer SHALL discard the transfer with no memory write, and pready SHALL remain 0 until a new setup after rst deasserts.
REQ-032 Memory array SHALL keep its contents across rst.

Verification
REQ-033 WAIT_STATES=1: write 0xDEADBEEF to 0x10 with pstrb=4'hF, then read 0x10 -> pready high in the 2nd access cycle, prdata=0xDEADBEEF, pslverr=0.
REQ-034 Write 0x11223344 to 0x20, then write 0xAABBCCDD with pstrb=4'b0101, then read 0x20 -> 0x11BB33DD.
REQ-035 Read from 0x3 and from 4*DEPTH_WORDS -> pslverr=1, prdata=0; a write to 0x3 leaves word 0 unchanged.
REQ-036 WAIT_STATES=0: back-to-back write to 0x40, then read of 0x40 with no idle cycle -> pready high in each first access cycle, read returns the written value.
REQ-037 psel dropped in WAIT during a write to 0x50, then 0x50 read -> old value returned, no pready pulse during the aborted transfer.
REQ-038 rst pulsed during WAIT -> pready=0 and prdata=0 next cycle, and earlier written memory is intact on a following read.

Source files
------------

// File: rtl/apb_sram_slave_if.sv
// APB bus bundle between a requester and the SRAM completer.
// Carries select/enable/direction, the byte address, write data and strobes
// toward the completer, and read data, ready and error back to the requester.
interface apb_sram_slave_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_sram_slave.sv
// APB completer fronting a word-organised SRAM with byte strobes.
// Latency: pready in access cycle WAIT_STATES+1, for one cycle.
// Backpressure: wait states via pready; dropping psel before pready aborts.
// Ports: clk, rst (sync, active-high); apb = APB completer modport
//   (psel, penable, pwrite, paddr, pwdata, pstrb in; prdata, pready, pslverr out).
module apb_sram_slave #(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst,
  apb_sram_slave_if.slave apb
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam bit         NO_WAIT  = (WAIT_STATES == 0);
  localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic          write_q;
  logic          err_q;
  logic [31:0]   wdata_q;
  logic [3:0]    strb_q;
  logic          rd_vld;
  logic [31:0]   rd_raw;
  logic [31:0]   mem [DEPTH_WORDS];

  logic setup;
  logic addr_err;
  logic commit;

  assign setup    = (state == IDLE) && apb.psel && !apb.penable;
  // Misaligned, or any address bit above the array's byte range set.
  assign addr_err = (apb.paddr[1:0] != 2'b00) || (apb.paddr[31:AW+2] != '0);
  // Write lands on the edge that ends a DONE cycle the requester still owns.
  assign commit   = (state == DONE) && apb.psel && write_q && !err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (setup) state_nxt = NO_WAIT ? DONE : WAIT;
      WAIT: begin
        if (!apb.psel)                       state_nxt = IDLE;
        else if (apb.penable && cnt == 4'd0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    apb.pready  = (state == DONE) && apb.psel;
    apb.pslverr = apb.pready && err_q;
    apb.prdata  = rd_vld ? rd_raw : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 32'h0;
      strb_q  <= 4'h0;
      rd_vld  <= 1'b0;
    end else if (setup) begin
      cnt     <= CNT_INIT;
      idx_q   <= apb.paddr[AW+1:2];
      write_q <= apb.pwrite;
      err_q   <= addr_err;
      wdata_q <= apb.pwdata;
      strb_q  <= apb.pstrb;
      // Only clean reads expose RAM data; writes and errors read as zero.
      rd_vld  <= !apb.pwrite && !addr_err;
    end else if (state == WAIT && apb.psel && apb.penable && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // RAM: no reset, so contents survive rst. Read data is captured only at
  // the setup edge, which keeps prdata stable through the access phase.
  always_ff @(posedge clk) begin
    if (setup) rd_raw <= mem[apb.paddr[AW+1:2]];
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_sram_slave.sv
// Bench for apb_sram_slave: three instances (0, 1 and 3 wait states) share
// one APB driver; psel is steered to the instance under test. A per-instance
// word array models memory, byte strobes, errors and expected timing.
module tb_apb_sram_slave;

  localparam int DEPTH = 32;
  localparam int LIMIT = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          dut_sel = 0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] pwdata = 32'h0;
  logic [3:0]  pstrb = 4'h0;
  logic [31:0] prdata_m;
  logic        pready_m;
  logic        pslverr_m;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mdl [3][DEPTH];

  always #5 clk = ~clk;

  apb_sram_slave_if if_ws0 ();
  apb_sram_slave_if if_ws1 ();
  apb_sram_slave_if if_ws3 ();

  assign if_ws0.psel = psel && (dut_sel == 0);
  assign if_ws1.psel = psel && (dut_sel == 1);
  assign if_ws3.psel = psel && (dut_sel == 2);
  assign {if_ws0.penable, if_ws1.penable, if_ws3.penable} = {3{penable}};
  assign {if_ws0.pwrite,  if_ws1.pwrite,  if_ws3.pwrite}  = {3{pwrite}};
  assign {if_ws0.paddr,   if_ws1.paddr,   if_ws3.paddr}   = {3{paddr}};
  assign {if_ws0.pwdata,  if_ws1.pwdata,  if_ws3.pwdata}  = {3{pwdata}};
  assign {if_ws0.pstrb,   if_ws1.pstrb,   if_ws3.pstrb}   = {3{pstrb}};

  apb_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (.clk(clk), .rst(rst), .apb(if_ws0));
  apb_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_ws1 (.clk(clk), .rst(rst), .apb(if_ws1));
  apb_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_ws3 (.clk(clk), .rst(rst), .apb(if_ws3));

  always_comb begin
    prdata_m  = if_ws0.prdata;
    pready_m  = if_ws0.pready;
    pslverr_m = if_ws0.pslverr;
    if (dut_sel == 1) begin
      prdata_m  = if_ws1.prdata;
      pready_m  = if_ws1.pready;
      pslverr_m = if_ws1.pslverr;
    end else if (dut_sel == 2) begin
      prdata_m  = if_ws3.prdata;
      pready_m  = if_ws3.pready;
      pslverr_m = if_ws3.pslverr;
    end
  end

  function automatic int ws_of(input int s);
    case (s)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= LIMIT);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transfer on the selected instance; leaves psel/penable high
  // so a following call runs back-to-back with no idle cycle.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string tag, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic [31:0] first_rd;
    bit          bad;
    bit          seen;
    int          k;
    bad    = addr_bad(a);
    exp_rd = (wr || bad) ? 32'h0 : mdl[dut_sel][a[6:2]];
    first_rd = 32'h0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(negedge clk);
    penable = 1'b1;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      k++;
      #1;
      if (k == 1) first_rd = prdata_m;
      if (pready_m) seen = 1'b1;
      else @(negedge clk);
    end
    rd = prdata_m;
    chk({tag, "_ready"},   32'(seen), 32'd1);
    chk({tag, "_cycles"},  32'(k), 32'(ws_of(dut_sel) + 1));
    chk({tag, "_pslverr"}, 32'(pslverr_m), 32'(bad));
    chk({tag, "_prdata"},  prdata_m, exp_rd);
    chk({tag, "_stable"},  first_rd, exp_rd);
    if (wr && !bad) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[dut_sel][a[6:2]][8*b +: 8] = d[8*b +: 8];
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  // Starts a write, runs n_acc access cycles, then drops psel.
  task automatic abort_wr(input int n_acc, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = 4'hF;
    for (int i = 0; i < n_acc; i++) begin
      @(negedge clk);
      penable = 1'b1;
      #1 chk("abort_access_pready", 32'(pready_m), 32'd0);
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b1;
    #1 chk("abort_drop_pready", 32'(pready_m), 32'd0);
    repeat (2) begin
      @(negedge clk);
      penable = 1'b0;
      #1 chk("abort_after_pready", 32'(pready_m), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] d;
    int          r;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_pready0",  32'(if_ws0.pready),  32'd0);
    chk("rst_pready1",  32'(if_ws1.pready),  32'd0);
    chk("rst_pready3",  32'(if_ws3.pready),  32'd0);
    chk("rst_pslverr1", 32'(if_ws1.pslverr), 32'd0);
    chk("rst_prdata0",  if_ws0.prdata, 32'h0);
    chk("rst_prdata1",  if_ws1.prdata, 32'h0);
    chk("rst_prdata3",  if_ws3.prdata, 32'h0);

    // Fill every word of every instance so the model is fully defined.
    for (int s = 0; s < 3; s++) begin
      dut_sel = s;
      for (int w = 0; w < DEPTH; w++) xfer(1'b1, 32'(w * 4), $urandom, 4'hF, "fill", rd);
      idle(1);
    end

    dut_sel = 1;
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "w_deadbeef", rd);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, "r_deadbeef", rd);
    chk("deadbeef_value", rd, 32'hDEADBEEF);

    xfer(1'b1, 32'h20, 32'h11223344, 4'hF, "w_20", rd);
    idle(1);
    xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "w_20_strb", rd);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, "r_20", rd);
    chk("strb_merge_value", rd, 32'h11BB33DD);

    xfer(1'b1, 32'h0, 32'h0BADF00D, 4'hF, "w_word0", rd);
    xfer(1'b0, 32'h3, 32'h0, 4'h0, "r_misaligned", rd);
    xfer(1'b0, 32'(LIMIT), 32'h0, 4'h0, "r_out_of_range", rd);
    xfer(1'b1, 32'h3, 32'hFFFFFFFF, 4'hF, "w_misaligned", rd);
    xfer(1'b0, 32'h0, 32'h0, 4'h0, "r_word0", rd);
    chk("err_write_no_effect", rd, 32'h0BADF00D);

    xfer(1'b1, 32'h24, 32'h5A5A5A5A, 4'h0, "w_nostrb", rd);
    xfer(1'b0, 32'h24, 32'h0, 4'h0, "r_nostrb", rd);

    xfer(1'b1, 32'h50, 32'h12345678, 4'hF, "w_50", rd);
    abort_wr(0, 32'h50, 32'hFFFFFFFF);
    xfer(1'b0, 32'h50, 32'h0, 4'h0, "r_50_after_abort", rd);
    chk("abort_keeps_old", rd, 32'h12345678);
    idle(1);

    dut_sel = 0;
    xfer(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, "w_40_b2b", rd);
    xfer(1'b0, 32'h40, 32'h0, 4'h0, "r_40_b2b", rd);
    chk("b2b_value", rd, 32'hCAFEF00D);
    idle(1);

    dut_sel = 2;
    abort_wr(1, 32'h30, 32'h01010101);
    abort_wr(3, 32'h34, 32'h02020202);
    xfer(1'b0, 32'h30, 32'h0, 4'h0, "r_30_after_abort", rd);
    xfer(1'b0, 32'h34, 32'h0, 4'h0, "r_34_after_abort", rd);

    // Reset in the middle of a read's wait phase.
    xfer(1'b1, 32'h44, 32'h87654321, 4'hF, "w_44", rd);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h44; pstrb = 4'h0;
    @(negedge clk);
    penable = 1'b1;
    #1 chk("mid_rst_prdata_before", prdata_m, 32'h87654321);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_pready", 32'(pready_m), 32'd0);
    chk("mid_rst_prdata", prdata_m, 32'h0);
    repeat (4) begin
      @(negedge clk);
      #1 chk("post_rst_no_pready", 32'(pready_m), 32'd0);
    end
    idle(1);
    xfer(1'b0, 32'h44, 32'h0, 4'h0, "r_44_after_rst", rd);
    chk("mem_survives_rst", rd, 32'h87654321);
    dut_sel = 1;
    xfer(1'b0, 32'h10, 32'h0, 4'h0, "r_10_after_rst", rd);
    idle(1);

    for (int s = 0; s < 3; s++) begin
      dut_sel = s;
      for (int t = 0; t < 80; t++) begin
        r = $urandom_range(0, 9);
        if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
        else if (r == 7) a = 32'($urandom_range(0, LIMIT - 1)) | 32'h1;
        else if (r == 8) a = 32'(LIMIT + 4 * $urandom_range(0, 63));
        else             a = $urandom;
        d = $urandom;
        xfer($urandom_range(0, 1) == 1, a, d, 4'($urandom_range(0, 15)), "rand", rd);
        if ($urandom_range(0, 2) == 0) idle(1);
      end
      idle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
